// File: rtl/oled_spi_sink.sv
// Receive-side decoder for the OLED SPI link: oversamples csn/clk/dat/dcn/rst in sys_clk,
// rebuilds MSB-first bytes, tags them with dc/page/column and queues them in a FWFT FIFO.
module oled_spi_sink #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int COL_MAX     = 127
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       oled_csn,
    input  logic       oled_clk,
    input  logic       oled_dat,
    input  logic       oled_dcn,
    input  logic       oled_rst,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic [2:0] byte_page,
    output logic [6:0] byte_col,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       overflow,
    output logic       frame_err,
    input  logic       err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 19;
    localparam logic [6:0] COL_LAST = 7'(COL_MAX);

    // ------------------------------------------------------------------
    // Input synchronizers; csn and panel reset idle at their inactive level
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic [SYNC_STAGES-1:0] dcn_sync;
    logic [SYNC_STAGES-1:0] rst_sync;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            csn_sync <= '1;
            clk_sync <= '0;
            dat_sync <= '0;
            dcn_sync <= '0;
            rst_sync <= '1;
        end else begin
            csn_sync <= {csn_sync[SYNC_STAGES-2:0], oled_csn};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], oled_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], oled_dat};
            dcn_sync <= {dcn_sync[SYNC_STAGES-2:0], oled_dcn};
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], oled_rst};
        end
    end

    logic csn_s;
    logic clk_s;
    logic dat_s;
    logic dcn_s;
    logic rst_s;

    assign csn_s = csn_sync[SYNC_STAGES-1];
    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    assign dcn_s = dcn_sync[SYNC_STAGES-1];
    assign rst_s = rst_sync[SYNC_STAGES-1];

    logic clk_prev;
    logic csn_prev;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_prev <= 1'b0;
            csn_prev <= 1'b1;
        end else begin
            clk_prev <= clk_s;
            csn_prev <= csn_s;
        end
    end

    logic sclk_rise;
    logic csn_rise;

    assign sclk_rise = clk_s & ~clk_prev & ~csn_s;
    assign csn_rise  = csn_s & ~csn_prev;

    // ------------------------------------------------------------------
    // Shift register, bit counter and address tracking
    // ------------------------------------------------------------------
    logic [7:0] shreg;
    logic [2:0] bitcnt;
    logic [2:0] page;
    logic [6:0] col;
    logic [7:0] next_byte;
    logic [2:0] page_next;
    logic [6:0] col_next;

    assign next_byte = {shreg[6:0], dat_s};

    always_comb begin
        page_next = page;
        col_next  = col;
        if (dcn_s) begin
            col_next = (col == COL_LAST) ? 7'd0 : col + 7'd1;
        end else if (next_byte[7:3] == 5'b10110) begin
            page_next = next_byte[2:0];
        end else if (next_byte[7:4] == 4'h0) begin
            col_next[3:0] = next_byte[3:0];
        end else if (next_byte[7:3] == 5'b00010) begin
            col_next[6:4] = next_byte[2:0];
        end
    end

    logic       push_req;
    logic [7:0] push_data;
    logic       push_dc;
    logic [2:0] push_page;
    logic [6:0] push_col;

    // A completed byte is staged here with the address it was received at,
    // while page/col move on to the value the byte implies.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shreg     <= '0;
            bitcnt    <= '0;
            page      <= '0;
            col       <= '0;
            push_req  <= 1'b0;
            push_data <= '0;
            push_dc   <= 1'b0;
            push_page <= '0;
            push_col  <= '0;
        end else begin
            push_req <= 1'b0;
            if (!rst_s) begin
                shreg  <= '0;
                bitcnt <= '0;
                page   <= '0;
                col    <= '0;
            end else if (csn_s) begin
                bitcnt <= '0;
            end else if (sclk_rise) begin
                shreg <= next_byte;
                if (bitcnt == 3'd7) begin
                    bitcnt    <= '0;
                    push_req  <= 1'b1;
                    push_data <= next_byte;
                    push_dc   <= dcn_s;
                    push_page <= page;
                    push_col  <= col;
                    page      <= page_next;
                    col       <= col_next;
                end else begin
                    bitcnt <= bitcnt + 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO; head shows the last written slot while empty
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          do_push;
    logic          drop;
    logic [AW-1:0] head_idx;
    logic [EW-1:0] head;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == PW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = ~empty & byte_ready & rst_s;
    assign do_push  = push_req & rst_s & (~full | pop);
    assign drop     = push_req & rst_s & full & ~pop;
    assign head_idx = empty ? AW'(rd_ptr - 1'b1) : rd_ptr[AW-1:0];
    assign head     = mem[head_idx];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!rst_s) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= {push_dc, push_page, push_col, push_data};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign byte_valid = ~empty;
    assign byte_dc    = head[18];
    assign byte_page  = head[17:15];
    assign byte_col   = head[14:8];
    assign byte_data  = head[7:0];

    // Sticky error flags; a new error outranks a clear in the same cycle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (csn_rise && bitcnt != 3'd0) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule
